div_chain_ctrl: RTL
===================

DIV_CHAIN_CTRL -- requirements
Module: div_chain_ctrl

Interface
REQ-001 SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 clk_ref  input  1  system clock, 100 MHz; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 en  input  1  run enable; high = divider chain counts, low = chain held idle.
REQ-005 sel  input  2  requested output tap: 0 = 1 MHz, 1 = 10 kHz, 2 = 100 Hz, 3 = off.
REQ-006 sel_valid  input  1  sel request strobe; the request transfers when sel_valid and sel_ready are both high on the same edge.
REQ-007 sel_ready  output  1  controller can accept a new tap request.
REQ-008 tick_1m, tick_10k, tick_100  output  1 each  single-cycle enable strobes at 1 MHz, 10 kHz and 100 Hz.
REQ-009 clk_out  output  1  50%-duty square wave of the active tap; 0 when the tap is off.
REQ-010 busy  output  1  a tap switch is pending.

Function
REQ-011 The block SHALL hold three counters c0, c1, c2, each 7 bits wide and ranging 0..99; c0 SHALL advance every RUN/SWITCH cycle, c1 SHALL advance when c0==99, and c2 SHALL advance when c0==99 and c1==99; each counter SHALL wrap 99->0.
REQ-012 tick_1m SHALL be (c0==99), tick_10k SHALL be (c0==99 && c1==99), and tick_100 SHALL be (c0==99 && c1==99 && c2==99); all ticks SHALL be gated to 0 in IDLE.
REQ-013 clk_out SHALL be high when the active tap counter (c0 for tap 0, c1 for tap 1, c2 for tap 2) is < 50, and low otherwise; clk_out SHALL be 0 for tap 3 and in IDLE.
REQ-014 The FSM SHALL have states IDLE, RUN and SWITCH, with the following transitions:
  - IDLE->RUN when en=1; counters SHALL be 0 on the first RUN cycle.
  - RUN->SWITCH on an accepted request whose sel differs from the active tap.
  - SWITCH->RUN on the apply edge (REQ-016).
  - RUN/SWITCH->IDLE when en=0; counters SHALL clear on that edge.
REQ-015 sel_ready SHALL be 0 in SWITCH and 1 otherwise; busy SHALL be 1 exactly in SWITCH; an accepted request SHALL be latched into pend_sel.
REQ-016 The apply edge is the edge where the tick of the slower tap of {active, pend_sel} is high, with off ranked as the other tap (off->off applies immediately); on that edge active SHALL take pend_sel, so that the new tap starts at counter 0 and clk_out has no runt pulse.
REQ-017 A request accepted in RUN whose sel equals the active tap SHALL be consumed without entering SWITCH.
REQ-018 A request accepted in IDLE SHALL update active on that edge, and the FSM SHALL remain in IDLE.
REQ-019 If en falls during SWITCH, pend_sel SHALL be applied to active on the same edge, the FSM SHALL go to IDLE, and busy SHALL clear.
REQ-020 sel_valid presented while sel_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-021 Counter arithmetic SHALL NOT overflow; a counter value above 99 is unreachable and SHALL NOT be required to be handled.

Reset
REQ-022 While rst=1, the following SHALL hold on the next edge:
  - state SHALL be IDLE.
  - c0, c1 and c2 SHALL be 0.
  - active and pend_sel SHALL be 2 (100 Hz).
  - tick_* and clk_out SHALL be 0; busy SHALL be 0; sel_ready SHALL be 1.
REQ-023 rst SHALL override en and sel_valid on the same edge, including mid-SWITCH; any pending request SHALL be discarded.

Verification
REQ-024 Reset, then en=1 held with tap 2 -> first tick_1m on RUN cycle 100, first tick_10k on cycle 10,000, first tick_100 on cycle 1,000,000; clk_out high for 500,000 cycles then low for 500,000.
REQ-025 IDLE: sel=0 with sel_valid -> active=0 on the next edge; then en=1 -> clk_out alternates 50 high / 50 low with period 100, and tick_1m fires every 100 cycles.
REQ-026 RUN tap 0: request sel=1 at c0=20, c1=37 -> busy=1 and sel_ready=0 until the edge with c0=99, c1=99; then busy=0, the first clk_out high lasts 5,000 cycles, and no pulse shorter than 50 cycles appears.
REQ-027 In SWITCH: a second sel_valid is ignored; deasserting en -> IDLE next edge, counters 0, clk_out=0, active equal to the pending tap.
REQ-028 RUN tap 1: request sel=3 -> clk_out stays on the tap-1 waveform until tick_10k, then is held 0 while tick_* continue.
REQ-029 Assert rst for 1 cycle mid-SWITCH with c0=55 -> next cycle IDLE, all counters 0, active=2, busy=0, sel_ready=1.

Source files
------------

// File: rtl/div_chain_ctrl_if.sv
// Tap-select handshake between a requester and div_chain_ctrl.
//   sel       : requested tap (0 = 1 MHz, 1 = 10 kHz, 2 = 100 Hz, 3 = off)
//   sel_valid : request strobe
//   sel_ready : controller can accept a request this cycle
interface div_chain_ctrl_if;
    logic [1:0] sel;
    logic       sel_valid;
    logic       sel_ready;

    modport master (output sel, output sel_valid, input  sel_ready);
    modport slave  (input  sel, input  sel_valid, output sel_ready);
endinterface

// File: rtl/div_chain_ctrl.sv
// Decimal divider chain (100 MHz -> 1 MHz -> 10 kHz -> 100 Hz) with glitch-free
// output tap switching. A tap change waits for the slower of the old/new taps to
// wrap, so clk_out never shows a runt pulse.
// Ports:
//   clk_ref  : 100 MHz system clock
//   rst      : synchronous active-high reset
//   en       : run enable for the chain
//   sel_if   : tap request handshake (slave side)
//   tick_1m, tick_10k, tick_100 : single-cycle enable strobes
//   clk_out  : 50% duty square wave of the active tap, 0 when off or idle
//   busy     : a tap switch is pending
module div_chain_ctrl (
    input  logic                   clk_ref,
    input  logic                   rst,
    input  logic                   en,
    div_chain_ctrl_if.slave        sel_if,
    output logic                   tick_1m,
    output logic                   tick_10k,
    output logic                   tick_100,
    output logic                   clk_out,
    output logic                   busy
);
    localparam int unsigned CW = 7;
    localparam logic [CW-1:0] CMAX = CW'(99);
    localparam logic [CW-1:0] CHALF = CW'(50);
    localparam logic [1:0] TAP_OFF = 2'd3;
    localparam logic [1:0] TAP_RST = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic [1:0]    active_q, active_d;
    logic [1:0]    pend_q, pend_d;

    logic w0, w1, w2;
    logic accept;
    logic [1:0] slow_tap;
    logic apply;

    // Raw wrap conditions of each stage of the chain.
    always_comb begin
        w0 = (c0_q == CMAX);
        w1 = w0 && (c1_q == CMAX);
        w2 = w1 && (c2_q == CMAX);
    end

    // Handshake and apply-edge detection; off ranks below every real tap.
    always_comb begin
        sel_if.sel_ready = (state_q != SWITCH);
        accept           = sel_if.sel_valid && (state_q != SWITCH);
        if (active_q == TAP_OFF)
            slow_tap = pend_q;
        else if (pend_q == TAP_OFF)
            slow_tap = active_q;
        else
            slow_tap = (active_q > pend_q) ? active_q : pend_q;
        case (slow_tap)
            2'd0:    apply = w0;
            2'd1:    apply = w1;
            2'd2:    apply = w2;
            default: apply = 1'b1;
        endcase
    end

    // Next-state, counter and tap registers.
    always_comb begin
        state_d  = state_q;
        c0_d     = c0_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        active_d = active_q;
        pend_d   = pend_q;

        if (state_q == IDLE || !en) begin
            c0_d = '0;
            c1_d = '0;
            c2_d = '0;
        end else begin
            c0_d = w0 ? '0 : c0_q + CW'(1);
            if (w0) c1_d = (c1_q == CMAX) ? '0 : c1_q + CW'(1);
            if (w1) c2_d = (c2_q == CMAX) ? '0 : c2_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) active_d = sel_if.sel;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    if (accept) active_d = sel_if.sel;
                    state_d = IDLE;
                end else if (accept && (sel_if.sel != active_q)) begin
                    pend_d  = sel_if.sel;
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                if (!en) begin
                    active_d = pend_q;
                    state_d  = IDLE;
                end else if (apply) begin
                    active_d = pend_q;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q  <= IDLE;
            c0_q     <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            active_q <= TAP_RST;
            pend_q   <= TAP_RST;
        end else begin
            state_q  <= state_d;
            c0_q     <= c0_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    // Outputs decode straight from registered state; everything is gated in IDLE.
    always_comb begin
        tick_1m  = (state_q != IDLE) && w0;
        tick_10k = (state_q != IDLE) && w1;
        tick_100 = (state_q != IDLE) && w2;
        busy     = (state_q == SWITCH);
        clk_out  = 1'b0;
        if (state_q != IDLE) begin
            case (active_q)
                2'd0:    clk_out = (c0_q < CHALF);
                2'd1:    clk_out = (c1_q < CHALF);
                2'd2:    clk_out = (c2_q < CHALF);
                default: clk_out = 1'b0;
            endcase
        end
    end
endmodule
